// File: rtl/ualink_pkg.sv
// Shared types and defaults for the ualink dual-port memory read engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ualink_pkg;

    localparam int DEF_DPDATA_WIDTH = 64;
    localparam int KEEP_WIDTH       = DEF_DPDATA_WIDTH / 8;
    localparam int DEF_OUT_DEPTH    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ualink_dpmem_reader_if.sv
// Command + AXI4-Stream bundle for the dpmem reader.
// Latency: n/a (wires only).
// Backpressure: cmd_ready gates commands, m_axis_tready stalls the stream.
// Ports: cmd_valid/ready/base_addr/len/last_keep, m_axis_tdata/tkeep/tlast/tvalid/tready.
// master = the reader (accepts commands, sources the stream); slave = its environment.
interface ualink_dpmem_reader_if
    import ualink_pkg::*;
#(
    parameter int DPADDR_WIDTH = 8,
    parameter int DPDATA_WIDTH = DEF_DPDATA_WIDTH,
    parameter int LEN_WIDTH    = DPADDR_WIDTH + 1
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [DPADDR_WIDTH-1:0]   cmd_base_addr;
    logic [LEN_WIDTH-1:0]      cmd_len;
    logic [DPDATA_WIDTH/8-1:0] cmd_last_keep;

    logic [DPDATA_WIDTH-1:0]   m_axis_tdata;
    logic [DPDATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                      m_axis_tlast;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;

    modport master (
        input  cmd_valid, cmd_base_addr, cmd_len, cmd_last_keep, m_axis_tready,
        output cmd_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

    modport slave (
        output cmd_valid, cmd_base_addr, cmd_len, cmd_last_keep, m_axis_tready,
        input  cmd_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );
endinterface

// File: rtl/ualink_axis_out_fifo.sv
// Output skid FIFO holding {tlast, tkeep, tdata}; head drives the stream directly.
// Latency: 1 clk push-to-head.
// Backpressure: caller must never push when full; pop only when head_vld.
// Ports: clk, rst (sync, active-high), push/push_dat, pop, head_dat/head_vld, count.
module ualink_axis_out_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       head_vld,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_vld = (count != '0);
    // Zero when empty so the stream outputs have defined values out of reset.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;
endmodule

// File: rtl/ualink_dpmem_reader.sv
// Streams cmd_len words from DPRAM port B as one AXI4-Stream frame, 1 beat/clk.
// Latency: accept -> first mem_addr 1 clk, -> first tvalid 3 clks.
// Backpressure: reads issue only while FIFO occupancy + in-flight read < OUT_DEPTH; tready never reaches mem_addr.
// Ports: axi_aclk, axi_reset (sync, active-high), bus (cmd + m_axis), mem_we/addr/din/dout, busy, done.
module ualink_dpmem_reader
    import ualink_pkg::*;
#(
    parameter int DPADDR_WIDTH = 8,
    parameter int DPDATA_WIDTH = DEF_DPDATA_WIDTH,
    parameter int LEN_WIDTH    = DPADDR_WIDTH + 1,
    parameter int OUT_DEPTH    = DEF_OUT_DEPTH
) (
    input  logic                    axi_aclk,
    input  logic                    axi_reset,
    ualink_dpmem_reader_if.master   bus,
    output logic                    mem_we,
    output logic [DPADDR_WIDTH-1:0] mem_addr,
    output logic [DPDATA_WIDTH-1:0] mem_din,
    input  logic [DPDATA_WIDTH-1:0] mem_dout,
    output logic                    busy,
    output logic                    done
);
    localparam int KW = DPDATA_WIDTH / 8;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [LEN_WIDTH-1:0] DEPTH_LEN = LEN_WIDTH'(2 ** DPADDR_WIDTH);

    state_t                  state;
    state_t                  state_nxt;
    logic [DPADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    issued;
    logic [KW-1:0]           keep_q;
    logic                    rd_pend;
    logic                    rd_last;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             occ;
    logic                    accept;
    logic                    issue;
    logic                    pop;
    logic [DPDATA_WIDTH+KW:0] head_dat;

    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign pop           = bus.m_axis_tvalid && bus.m_axis_tready;

    // Count the in-flight read as occupied so the FIFO can always absorb it.
    assign occ   = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend};
    assign issue = (state == READ) && (issued != len_q) && (occ < (CW+1)'(OUT_DEPTH));

    assign mem_we   = 1'b0;
    assign mem_din  = '0;
    // Address width truncation gives the FF -> 00 wrap for free.
    assign mem_addr = (state == READ) ? base_q + issued[DPADDR_WIDTH-1:0] : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && (bus.cmd_len != '0)) state_nxt = READ;
            READ:    if (issued == len_q) state_nxt = DRAIN;
            DRAIN:   if (pop && bus.m_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state   <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            issued  <= '0;
            keep_q  <= '0;
            rd_pend <= 1'b0;
            rd_last <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= issue;
            rd_last <= issue && (issued == len_q - 1'b1);
            // Zero-length commands complete immediately without leaving IDLE.
            done    <= (accept && (bus.cmd_len == '0)) ||
                       ((state == DRAIN) && pop && bus.m_axis_tlast);
            if (accept) begin
                base_q <= bus.cmd_base_addr;
                len_q  <= (bus.cmd_len > DEPTH_LEN) ? DEPTH_LEN : bus.cmd_len;
                keep_q <= (bus.cmd_last_keep == '0) ? {KW{1'b1}} : bus.cmd_last_keep;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + 1'b1;
            end
        end
    end

    ualink_axis_out_fifo #(
        .WIDTH (DPDATA_WIDTH + KW + 1),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (axi_aclk),
        .rst      (axi_reset),
        .push     (rd_pend),
        .push_dat ({rd_last, (rd_last ? keep_q : {KW{1'b1}}), mem_dout}),
        .pop      (pop),
        .head_dat (head_dat),
        .head_vld (bus.m_axis_tvalid),
        .count    (fifo_count)
    );

    assign {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} = head_dat;
endmodule
